// File: rtl/permute_arb_stage_if.sv
// permute_arb_stage_if: two flit lanes in/out, swap decision and deflection counter.
// Flit width comes from `WIDTH_INTERNAL_PV (global.v); a 16-bit fallback keeps the bundle standalone.
`ifndef WIDTH_INTERNAL_PV
`define WIDTH_INTERNAL_PV 16
`endif
interface permute_arb_stage_if #(
    parameter int W     = `WIDTH_INTERNAL_PV,
    parameter int CNT_W = 16
);
    logic [W-1:0]     inFlit0, inFlit1, outFlit0, outFlit1;
    logic             swap, cnt_clr;
    logic [CNT_W-1:0] deflect_cnt;
    modport master(output inFlit0, inFlit1, cnt_clr, input outFlit0, outFlit1, swap, deflect_cnt);
    modport slave(input inFlit0, inFlit1, cnt_clr, output outFlit0, outFlit1, swap, deflect_cnt);
endinterface

// File: rtl/permute_arb_stage.sv
// permute_arb_stage: registers a flit pair and precomputes the permuter swap with age/tiebreak arbitration.
// Optional PERMUTE_AGE_INC_EN: valid flits leave with their age field incremented (saturating).
`ifndef WIDTH_INTERNAL_PV
`define WIDTH_INTERNAL_PV 16
`endif
module permute_arb_stage #(
    parameter int AGE_W = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    permute_arb_stage_if.slave bus
);
    localparam int W   = `WIDTH_INTERNAL_PV;
    localparam int AHI = W - 3;
    logic             v0, v1, p0, p1, tb, conflict, tie, winner, swapNext;
    logic [AGE_W-1:0] a0, a1;
    logic [W-1:0]     next0, next1;
`ifdef PERMUTE_AGE_INC_EN
    function automatic logic [W-1:0] bumpAge(input logic [W-1:0] f);
        logic [AGE_W-1:0] a;
        logic [W-1:0]     r;
        a = f[AHI -: AGE_W];
        r = f;
        if (f[W-1] && a != '1) r[AHI -: AGE_W] = a + 1'b1;
        return r;
    endfunction
    assign next0 = bumpAge(bus.inFlit0);
    assign next1 = bumpAge(bus.inFlit1);
`else
    assign next0 = bus.inFlit0;
    assign next1 = bus.inFlit1;
`endif
    always_comb begin
        v0       = bus.inFlit0[W-1];
        v1       = bus.inFlit1[W-1];
        p0       = bus.inFlit0[W-2];
        p1       = bus.inFlit1[W-2];
        a0       = bus.inFlit0[AHI -: AGE_W];
        a1       = bus.inFlit1[AHI -: AGE_W];
        conflict = v0 && v1 && (p0 == p1);
        tie      = conflict && (a0 == a1);
        winner   = (a0 > a1) ? 1'b0 : (a1 > a0) ? 1'b1 : tb;
        // different prefs with both valid fall into the v0 arm: swap follows lane 0's pref
        swapNext = conflict ? (winner != p0) : v0 ? p0 : (v1 & ~p1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outFlit0    <= '0;
            bus.outFlit1    <= '0;
            bus.swap        <= 1'b0;
            tb              <= 1'b0;
            bus.deflect_cnt <= '0;
        end else begin
            bus.outFlit0    <= next0;
            bus.outFlit1    <= next1;
            bus.swap        <= swapNext;
            tb              <= tb ^ tie;
            bus.deflect_cnt <= bus.cnt_clr ? '0 :
                               (conflict && bus.deflect_cnt != '1) ? bus.deflect_cnt + 1'b1 :
                               bus.deflect_cnt;
        end
    end
endmodule

// File: tb/tb_permute_arb_stage.sv
// tb_permute_arb_stage: random + directed stimulus checked against a behavioural arbitration model.
`ifndef WIDTH_INTERNAL_PV
`define WIDTH_INTERNAL_PV 16
`endif
module tb_permute_arb_stage;
    localparam int W    = `WIDTH_INTERNAL_PV;
    localparam int AMAX = 15;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int compared = 0;
    int mismatched = 0;
    int mTb, mCnt, mSat;
    logic [W-1:0] eOut0, eOut1;
    logic eSwap;
    always #5 clk = ~clk;
    permute_arb_stage_if #(.W(W), .CNT_W(16)) bus ();
    permute_arb_stage_if #(.W(W), .CNT_W(2))  busSat ();
    assign busSat.inFlit0 = bus.inFlit0;
    assign busSat.inFlit1 = bus.inFlit1;
    assign busSat.cnt_clr = bus.cnt_clr;
    permute_arb_stage #(.AGE_W(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    permute_arb_stage #(.AGE_W(4), .CNT_W(2))  dutSat (.clk(clk), .rst_n(rst_n), .bus(busSat));

    function automatic logic [W-1:0] mk(input int v, input int p, input int age, input int pay);
        logic [W-1:0] f;
        f = '0;
        f[W-1] = v[0];
        f[W-2] = p[0];
        f[W-3 -: 4] = age[3:0];
        f[W-7:0] = pay[W-7:0];
        return f;
    endfunction

    function automatic logic [W-1:0] ageOut(input logic [W-1:0] f);
        logic [W-1:0] r;
        int a;
        r = f;
        a = int'(f[W-3 -: 4]);
`ifdef PERMUTE_AGE_INC_EN
        if (f[W-1]) a = (a < AMAX) ? a + 1 : AMAX;
`endif
        r[W-3 -: 4] = a[3:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_out0"}, 64'(bus.outFlit0), 64'd0);
        check({tag, "_out1"}, 64'(bus.outFlit1), 64'd0);
        check({tag, "_swap"}, 64'(bus.swap), 64'd0);
        check({tag, "_cnt"}, 64'(bus.deflect_cnt), 64'd0);
        check({tag, "_satcnt"}, 64'(busSat.deflect_cnt), 64'd0);
    endtask

    // model: pick the lane whose preference is honoured, swap iff that lane's pref differs from its index
    task automatic step(input logic [W-1:0] f0, input logic [W-1:0] f1, input bit clr);
        int v0, v1, p0, p1, a0, a1, r, prefR;
        bit conflict;
        v0 = int'(f0[W-1]); v1 = int'(f1[W-1]);
        p0 = int'(f0[W-2]); p1 = int'(f1[W-2]);
        a0 = int'(f0[W-3 -: 4]); a1 = int'(f1[W-3 -: 4]);
        bus.inFlit0 = f0;
        bus.inFlit1 = f1;
        bus.cnt_clr = clr;
        r = -1;
        conflict = 1'b0;
        if (v0 == 1 && v1 == 1) begin
            if (p0 != p1) r = 0;
            else begin
                conflict = 1'b1;
                if (a0 > a1) r = 0;
                else if (a1 > a0) r = 1;
                else begin
                    r = mTb;
                    mTb = 1 - mTb;
                end
            end
        end else if (v0 == 1) r = 0;
        else if (v1 == 1) r = 1;
        prefR = (r == 0) ? p0 : p1;
        eSwap = (r >= 0) && (prefR != r);
        if (clr) begin
            mCnt = 0;
            mSat = 0;
        end else if (conflict) begin
            mCnt = (mCnt < 65535) ? mCnt + 1 : mCnt;
            mSat = (mSat < 3) ? mSat + 1 : 3;
        end
        eOut0 = ageOut(f0);
        eOut1 = ageOut(f1);
        @(posedge clk);
        #1;
        check("outFlit0", 64'(bus.outFlit0), 64'(eOut0));
        check("outFlit1", 64'(bus.outFlit1), 64'(eOut1));
        check("swap", 64'(bus.swap), 64'(eSwap));
        check("deflect_cnt", 64'(bus.deflect_cnt), 64'(mCnt));
        check("deflect_cnt_sat", 64'(busSat.deflect_cnt), 64'(mSat));
    endtask

    task automatic doReset(input int cycles);
        #2 rst_n = 1'b0;
        #1;
        mTb = 0; mCnt = 0; mSat = 0;
        checkZero("rst_async");
        repeat (cycles) begin
            bus.inFlit0 = mk(1, 1, $urandom_range(0, 15), $urandom);
            bus.inFlit1 = mk(1, 1, $urandom_range(0, 15), $urandom);
            bus.cnt_clr = 1'b0;
            @(posedge clk);
            #1;
            checkZero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit tieExp [4];
        logic [W-1:0] f0, f1;
        tieExp = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.inFlit0 = '0;
        bus.inFlit1 = '0;
        bus.cnt_clr = 1'b0;
        #1;
        doReset(3);
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 1, 5, 16 + i), mk(1, 1, 5, 32 + i), 1'b0);
            check("tie_swap_lit", 64'(bus.swap), 64'(tieExp[i]));
        end
        check("tie_cnt_lit", 64'(bus.deflect_cnt), 64'd4);
        check("sat_cnt_lit4", 64'(busSat.deflect_cnt), 64'd3);
        step(mk(1, 0, 3, 1), mk(1, 0, 7, 2), 1'b0);
        check("age_lane1_swap_lit", 64'(bus.swap), 64'd1);
        check("age_lane1_cnt_lit", 64'(bus.deflect_cnt), 64'd5);
        check("sat_cnt_lit5", 64'(busSat.deflect_cnt), 64'd3);
        step(mk(1, 0, 7, 3), mk(1, 0, 3, 4), 1'b0);
        check("age_lane0_swap_lit", 64'(bus.swap), 64'd0);
        check("age_lane0_cnt_lit", 64'(bus.deflect_cnt), 64'd6);
        step(mk(1, 1, 2, 5), mk(1, 1, 9, 6), 1'b1);
        check("clr_wins_lit", 64'(bus.deflect_cnt), 64'd0);
        check("clr_wins_sat_lit", 64'(busSat.deflect_cnt), 64'd0);
        f0 = mk(1, 1, 2, 'h155);
        f1 = mk(0, 0, 9, 'h0aa);
        step(f0, f1, 1'b0);
        check("single_swap_lit", 64'(bus.swap), 64'd1);
`ifdef PERMUTE_AGE_INC_EN
        check("single_out0_lit", 64'(bus.outFlit0), 64'(mk(1, 1, 3, 'h155)));
`else
        check("single_out0_lit", 64'(bus.outFlit0), 64'(f0));
`endif
        check("single_out1_lit", 64'(bus.outFlit1), 64'(f1));
        check("single_cnt_lit", 64'(bus.deflect_cnt), 64'd0);
        step(mk(1, 0, 14, 7), mk(1, 1, 15, 8), 1'b0);
`ifdef PERMUTE_AGE_INC_EN
        check("age14_lit", 64'(bus.outFlit0[W-3 -: 4]), 64'd15);
`else
        check("age14_lit", 64'(bus.outFlit0[W-3 -: 4]), 64'd14);
`endif
        check("age15_lit", 64'(bus.outFlit1[W-3 -: 4]), 64'd15);
        step(mk(0, 1, 14, 9), mk(0, 0, 15, 10), 1'b0);
        check("inv_age_lit", 64'(bus.outFlit0[W-3 -: 4]), 64'd14);
        check("inv_swap_lit", 64'(bus.swap), 64'd0);
        for (int n = 0; n < 500; n++) begin
            if (n % 150 == 149) doReset(2);
            f0 = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 15), $urandom);
            f1 = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 15), $urandom);
            step(f0, f1, $urandom_range(0, 19) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
